// File: rtl/serial_frame_tx.sv
// serial_frame_tx: sends start pattern, 8-bit length header and len payload bits MSB-first, then an idle gap.
module serial_frame_tx #(
    parameter int         START_LEN = 4,
    parameter logic [7:0] START_PAT = 8'b0000_1101,
    parameter int         MIN_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_valid,
    output logic       frame_ready,
    input  logic [7:0] len,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic [7:0] data_in,
    output logic       ser_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);
    typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, GAP} state_t;

    localparam logic [7:0] PAT_MSB  = START_PAT << (8 - START_LEN);
    localparam logic [7:0] PAT_REST = PAT_MSB << 1;
    localparam logic [7:0] PRE_CNT  = 8'(START_LEN - 1);
    localparam logic [7:0] GAP_CNT  = 8'(MIN_GAP - 1);

    state_t     state_q;
    logic [7:0] cnt_q, len_q, shift_q, hold_q;
    logic [5:0] bytes_left_q;
    logic       hold_full_q, ser_q, done_q, underrun_q;
    logic [8:0] len_up;
    logic [2:0] sent_lo;
    logic       last, boundary, take;

    assign len_up   = {1'b0, len} + 9'd7;
    assign last     = cnt_q == 8'd0;
    // payload bits already on the line (mod 8), counting the current one
    assign sent_lo  = len_q[2:0] - cnt_q[2:0];
    assign boundary = state_q == PAY && !last && sent_lo == 3'd0;
    assign take     = data_ready && data_valid;

    assign frame_ready = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign data_ready  = !hold_full_q && bytes_left_q != 6'd0 && (state_q inside {PRE, HDR, PAY});
    assign ser_out     = ser_q;
    assign done        = done_q;
    assign underrun    = underrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            len_q        <= 8'd0;
            shift_q      <= 8'd0;
            hold_q       <= 8'd0;
            bytes_left_q <= 6'd0;
            hold_full_q  <= 1'b0;
            ser_q        <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (take) begin
                hold_q       <= data_in;
                hold_full_q  <= 1'b1;
                bytes_left_q <= bytes_left_q - 6'd1;
            end
            case (state_q)
                IDLE: if (frame_valid) begin
                    state_q      <= PRE;
                    len_q        <= len;
                    underrun_q   <= 1'b0;
                    hold_full_q  <= 1'b0;
                    bytes_left_q <= len_up[8:3];
                    cnt_q        <= PRE_CNT;
                    ser_q        <= PAT_MSB[7];
                    shift_q      <= PAT_REST;
                end
                PRE: if (last) begin
                    state_q <= HDR;
                    cnt_q   <= 8'd7;
                    ser_q   <= len_q[7];
                    shift_q <= {len_q[6:0], 1'b0};
                end else begin
                    cnt_q   <= cnt_q - 8'd1;
                    ser_q   <= shift_q[7];
                    shift_q <= {shift_q[6:0], 1'b0};
                end
                HDR, PAY: if (last && (state_q == PAY || len_q == 8'd0)) begin
                    state_q <= GAP;
                    cnt_q   <= GAP_CNT;
                    ser_q   <= 1'b0;
                    done_q  <= 1'b1;
                end else if (last || boundary) begin
                    if (hold_full_q) begin
                        state_q     <= PAY;
                        cnt_q       <= last ? len_q - 8'd1 : cnt_q - 8'd1;
                        ser_q       <= hold_q[7];
                        shift_q     <= {hold_q[6:0], 1'b0};
                        hold_full_q <= 1'b0;
                    end else begin
                        state_q    <= GAP;
                        cnt_q      <= GAP_CNT;
                        ser_q      <= 1'b0;
                        underrun_q <= 1'b1;
                    end
                end else begin
                    cnt_q   <= cnt_q - 8'd1;
                    ser_q   <= shift_q[7];
                    shift_q <= {shift_q[6:0], 1'b0};
                end
                GAP: begin
                    ser_q   <= 1'b0;
                    cnt_q   <= cnt_q - 8'd1;
                    state_q <= last ? IDLE : GAP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: table-driven frames checked cycle by cycle against a queue of expected line states.
module tb_serial_frame_tx;
    localparam int START_LEN = 4;
    localparam int MIN_GAP   = 2;

    logic       clk, rst, frame_valid, frame_ready, data_valid, data_ready;
    logic       ser_out, busy, done, underrun;
    logic [7:0] len, data_in;

    serial_frame_tx dut (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .len(len), .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .ser_out(ser_out), .busy(busy), .done(done), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic ser;
        logic dn;
        logic und;
    } rec_t;

    typedef struct {
        logic [7:0]       len;
        int               nprov;
        logic [3:0][7:0]  d;
        int               exp_hs;
        logic             exp_under;
    } vec_t;

    rec_t       exp_q[$];
    logic [7:0] feed[$];
    logic [7:0] mb[$];
    int         n_chk = 0, n_err = 0, cyc = 0, hs = 0, n_acc = 0, acc_cyc = 0, acc_cyc_prev = 0;
    bit         hold_fv = 0;
    logic       under_m = 1'b0;
    logic [3:0] pat = 4'b1101;

    task automatic chk(input string nm, input logic a, input logic e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b, want %b", nm, cyc, a, e);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d, want %0d", nm, cyc, a, e);
        end
    endtask

    task automatic push(input logic s, input logic d, input logic u);
        rec_t r;
        r.ser = s;
        r.dn  = d;
        r.und = u;
        exp_q.push_back(r);
    endtask

    task automatic drive_feed();
        data_valid = feed.size() > 0;
        data_in    = feed.size() > 0 ? feed[0] : 8'h00;
    endtask

    // Builds the expected line for a frame accepted at this edge from the bytes offered to it.
    task automatic accept();
        logic [7:0] pb[$];
        int         nb, av, nbits;
        bit         ab;
        acc_cyc_prev = acc_cyc;
        acc_cyc      = cyc;
        n_acc++;
        hs = 0;
        nb = (int'(len) + 7) / 8;
        av = 0;
        while (av < nb && mb.size() > 0) begin
            pb.push_back(mb.pop_front());
            av++;
        end
        ab    = av < nb;
        nbits = ab ? 8 * av : int'(len);
        for (int i = START_LEN - 1; i >= 0; i--) push(pat[i], 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) push(len[i], 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) push(pb[i / 8][7 - i % 8], 1'b0, 1'b0);
        for (int g = 0; g < MIN_GAP; g++) push(1'b0, !ab && g == 0, ab);
        under_m = ab;
    endtask

    task automatic tick();
        rec_t r;
        bit   acc;
        acc = 0;
        @(negedge clk);
        cyc++;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("ser_out", ser_out, r.ser);
            chk("busy", busy, 1'b1);
            chk("done", done, r.dn);
            chk("underrun", underrun, r.und);
            chk("frame_ready_busy", frame_ready, 1'b0);
        end else begin
            chk("idle_ser_out", ser_out, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_underrun", underrun, under_m);
            chk("idle_frame_ready", frame_ready, 1'b1);
            chk("idle_data_ready", data_ready, 1'b0);
        end
        if (data_valid && data_ready) begin
            hs++;
            void'(feed.pop_front());
        end
        if (frame_valid && frame_ready) begin
            accept();
            acc = 1;
        end
        @(posedge clk);
        #1;
        if (acc && !hold_fv) frame_valid = 1'b0;
        drive_feed();
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (frame_valid && n < 50) begin tick(); n++; end
        if (frame_valid) begin
            chk_int({nm, "_accept_timeout"}, n, 0);
            frame_valid = 1'b0;
        end
        n = 0;
        while (exp_q.size() > 0 && n < 600) begin tick(); n++; end
        if (exp_q.size() > 0) chk_int({nm, "_frame_timeout"}, n, 0);
    endtask

    vec_t vec[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, n;
        vec[0] = '{8'd0,  0, 32'h0000_0000, 0, 1'b0};
        vec[1] = '{8'd8,  2, 32'h0000_11A5, 1, 1'b0};
        vec[2] = '{8'd12, 2, 32'h0000_9CF0, 2, 1'b0};
        vec[3] = '{8'd16, 1, 32'h0000_003C, 1, 1'b1};
        vec[4] = '{8'd3,  1, 32'h0000_00B7, 1, 1'b0};
        vec[5] = '{8'd0,  1, 32'h0000_00FF, 0, 1'b0};
        vec[6] = '{8'd20, 3, 32'h005A_C381, 3, 1'b0};
        vec[7] = '{8'd9,  1, 32'h0000_0042, 1, 1'b1};
        vec[8] = '{8'd24, 0, 32'h0000_0000, 0, 1'b1};
        vec[9] = '{8'd5,  1, 32'h0000_0080, 1, 1'b0};

        rst = 1'b1; frame_valid = 1'b0; len = 8'd0; data_valid = 1'b0; data_in = 8'd0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ser_out", ser_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_data_ready", data_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) tick();

        for (int i = 0; i < 10; i++) begin
            feed.delete();
            mb.delete();
            for (int b = 0; b < vec[i].nprov; b++) begin
                feed.push_back(vec[i].d[b]);
                mb.push_back(vec[i].d[b]);
            end
            drive_feed();
            len = vec[i].len;
            frame_valid = 1'b1;
            wait_done("vec");
            tick();
            chk_int("vec_handshakes", hs, vec[i].exp_hs);
            chk("vec_underrun_end", underrun, vec[i].exp_under);
            feed.delete();
            mb.delete();
            drive_feed();
        end

        // back-to-back requests with frame_valid held, third frame reset mid-header
        feed = '{8'hC3, 8'h5A, 8'hE7};
        mb   = '{8'hC3, 8'h5A, 8'hE7};
        drive_feed();
        len = 8'd8;
        hold_fv = 1;
        frame_valid = 1'b1;
        a0 = n_acc;
        n = 0;
        while (n_acc < a0 + 2 && n < 200) begin tick(); n++; end
        chk_int("b2b_spacing_1", acc_cyc - acc_cyc_prev, START_LEN + 8 + 8 + MIN_GAP + 1);
        while (n_acc < a0 + 3 && n < 300) begin tick(); n++; end
        chk_int("b2b_accepts", n_acc - a0, 3);
        chk_int("b2b_spacing_2", acc_cyc - acc_cyc_prev, START_LEN + 8 + 8 + MIN_GAP + 1);
        hold_fv = 0;
        frame_valid = 1'b0;
        repeat (8) tick();
        chk("pre_rst_ser_out", ser_out, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_rst_ser_out", ser_out, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", done, 1'b0);
        exp_q.delete();
        under_m = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("in_rst_ser_out", ser_out, 1'b0);
            chk("in_rst_done", done, 1'b0);
            chk("in_rst_busy", busy, 1'b0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        feed.delete();
        mb.delete();
        drive_feed();
        repeat (3) tick();

        feed = '{8'h96};
        mb   = '{8'h96};
        drive_feed();
        len = 8'd8;
        frame_valid = 1'b1;
        wait_done("post_rst");
        tick();
        chk_int("post_rst_handshakes", hs, 1);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Framing serializer that drives the single-bit serial line consumed by the frame-receiver controller. A frame request carries an 8-bit payload length. Payload bytes arrive over a valid/ready stream. The block emits a fixed start pattern, then the 8-bit length header MSB-first, then exactly `len` payload bits MSB-first, then a mandatory idle gap. Its `ser_out` connects directly to the receiver's serial input.

## Interface
- `START_LEN`, 4: start-pattern length in bits (1..8).
- `START_PAT`, 4'b1101: start pattern, sent MSB-first; must contain at least one 1.
- `MIN_GAP`, 2: idle cycles (line = 0) forced after every frame or abort (>=1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `frame_valid` in 1: frame request.
- `frame_ready` out 1: block can accept a request.
- `len` in 8: payload length in bits (0..255); sampled on request handshake.
- `data_valid` in 1: payload byte available.
- `data_ready` out 1: block takes the byte this cycle.
- `data_in` in 8: payload byte, MSB sent first.
- `ser_out` out 1: registered serial line; idle level 0.
- `busy` out 1: frame in progress, including the gap.
- `done` out 1: one-cycle pulse on successful frame completion.
- `underrun` out 1: sticky abort flag; cleared on next request accept.

## Operation
- States:
  - IDLE → PRE (`START_LEN` cycles) → HDR (8 cycles) → PAY (`len` cycles; skipped when `len`=0) → GAP (`MIN_GAP` cycles) → IDLE.
  - Any state → IDLE asynchronously on reset.
- IDLE:
  - `frame_ready`=1, `ser_out`=0.
  - On `frame_valid` & `frame_ready`, latch `len`, clear `underrun`, enter PRE.
- Bit counter: 8-bit down-counter reloaded on every state entry; state advances when it reaches terminal count.
- Payload buffering: shift register plus one-byte holding register.
  - `bytes_left` = ceil(`len`/8), computed at accept.
  - `data_ready` = holding register empty & `bytes_left`>0 & state ∈ {PRE, HDR, PAY}.
  - Each handshake loads the holding register and decrements `bytes_left`.
  - Prefetch of the first byte therefore starts in the first PRE cycle.
- Shifting: on entry to PAY and at every byte boundary within PAY, the holding byte moves into the shift register. The last byte sends only its upper (`len` mod 8, or 8) bits; the remaining bits are discarded.
- Underrun: if a byte boundary in PAY finds the holding register empty:
  - Abort the frame and set `underrun`.
  - Drive `ser_out`=0 from that cycle.
  - Enter GAP; no `done` pulse.
- `data_valid` in IDLE/GAP is ignored (`data_ready`=0). Extra bytes beyond `bytes_left` are never accepted.
- Reset values:
  - `ser_out`=0, `busy`=0, `done`=0, `underrun`=0, `data_ready`=0.
  - `frame_ready`=1 once reset deasserts.
  - All counters and registers cleared.
- Reset mid-frame: line drops to 0 immediately (async). No partial frame resumes.

## Timing
- Request accepted at edge T:
  - `busy`=1 from T+1.
  - `ser_out` carries `START_PAT`[START_LEN-1] in cycle T+1.
  - Header bits occupy T+1+`START_LEN` .. T+8+`START_LEN`.
  - Payload occupies the next `len` cycles.
- Frame line time = `START_LEN`+8+`len` cycles; no bubbles inside a frame.
- `done` pulses in the first GAP cycle after a successful frame.
- `busy` falls and `frame_ready` rises after `MIN_GAP` GAP cycles.
- Minimum frame-to-frame spacing = line time + `MIN_GAP` + 1 (IDLE accept cycle).
- `frame_ready`, `data_ready` and `busy` are decoded from state and registers only, never combinationally from `frame_valid` or `data_valid`.
- `done` and `underrun` are registered.

## Test plan
- Reset, then hold `frame_valid`=0 for 10 cycles → `ser_out`=0, `busy`=0, `done`=0, `underrun`=0, `frame_ready`=1 throughout.
- Request `len`=0 at T → `ser_out` = 1,1,0,1 then 0x00 header over T+1..T+12; `done` at T+13; `frame_ready`=1 at T+15; `data_ready` never asserted.
- Request `len`=8, one byte 0xA5 always valid → header 00001000 on T+5..T+12; payload 1,0,1,0,0,1,0,1 on T+13..T+20; exactly one data handshake; `done` at T+21.
- Request `len`=12, bytes 0xF0 then 0x9C → payload 11110000 1001; second byte's low nibble dropped; exactly two handshakes; `done` at T+25.
- Request `len`=16, provide first byte only → after 8 payload bits `ser_out`=0, `underrun`=1, no `done`. Next request clears `underrun` and sends a clean frame.
- Back-to-back requests with `frame_valid` held high, plus `rst` pulsed low mid-header on a third frame → second frame's first start bit appears exactly `MIN_GAP`+1 cycles after the first frame's last bit. During the reset pulse, `ser_out`=0 and `busy`=0 immediately, with no `done` pulse.
